// File: rtl/normalizer.sv
// Multi-cycle left-normalizer: shifts the operand left one bit per clock until it
// is normalized (unsigned or signed) and reports the shift amount behind start/done.
module normalizer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] in,
  input  logic        mode,
  output logic        busy,
  output logic        done,
  output logic [15:0] out,
  output logic [3:0]  shamt,
  output logic        zero
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] wreg;
  logic [3:0]  cnt;
  logic        mode_q;
  logic        zcls;
  logic        normed;
  logic        finish;
  logic        in_zcls;
  logic        accept;

  assign normed  = mode_q ? (wreg[15] ^ wreg[14]) : wreg[15];
  assign finish  = zcls | normed | (cnt == 4'd15);
  assign in_zcls = (in == 16'h0000) | (mode & (in == 16'hFFFF));
  assign accept  = start & (state != SHIFT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (finish) state_nxt = DONE;
      DONE:    state_nxt = start ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == SHIFT);
    done = (state == DONE);
  end

  // Results only update on the SHIFT->DONE transition, so they hold through the next operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wreg   <= 16'h0000;
      cnt    <= 4'd0;
      mode_q <= 1'b0;
      zcls   <= 1'b0;
      out    <= 16'h0000;
      shamt  <= 4'd0;
      zero   <= 1'b0;
    end else if (accept) begin
      wreg   <= in;
      cnt    <= 4'd0;
      mode_q <= mode;
      zcls   <= in_zcls;
    end else if (state == SHIFT) begin
      if (finish) begin
        out   <= wreg;
        shamt <= cnt;
        zero  <= zcls;
      end else begin
        wreg <= {wreg[14:0], 1'b0};
        cnt  <= cnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_normalizer.sv
// Testbench for normalizer: vector table plus handshake/reset sequences and random
// operands, with expected results queued at start and compared when done pulses.
module tb_normalizer;

  typedef struct {
    logic [15:0] in;
    logic        mode;
    logic [15:0] out;
    logic [3:0]  shamt;
    logic        zero;
    int          c0;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] opnd;
  logic        mode_s;
  logic        busy;
  logic        done;
  logic [15:0] out;
  logic [3:0]  shamt;
  logic        zero;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  exp_t q[$];
  exp_t vec[11];
  logic [15:0] last_out = 16'h0000;
  logic [3:0]  last_shamt = 4'd0;
  logic        last_zero = 1'b0;
  logic        prev_done = 1'b0;

  normalizer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .in    (opnd),
    .mode  (mode_s),
    .busy  (busy),
    .done  (done),
    .out   (out),
    .shamt (shamt),
    .zero  (zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(logic [15:0] v, logic m, logic [15:0] o, logic [3:0] s, logic z);
    exp_t r;
    r.in = v; r.mode = m; r.out = o; r.shamt = s; r.zero = z; r.c0 = 0;
    return r;
  endfunction

  // Reference: count leading zeros / redundant sign bits directly from the operand.
  function automatic exp_t model(logic [15:0] v, logic m);
    exp_t r;
    int   n;
    logic stop;
    r.in = v; r.mode = m; r.c0 = 0;
    if (v == 16'h0000 || (m && v == 16'hFFFF)) begin
      r.out = v; r.shamt = 4'd0; r.zero = 1'b1;
    end else begin
      n = 0;
      stop = 1'b0;
      if (!m) begin
        for (int i = 15; i >= 0; i--) if (!stop && !v[i]) n++; else stop = 1'b1;
      end else begin
        for (int i = 14; i >= 0; i--) if (!stop && v[i] == v[15]) n++; else stop = 1'b1;
      end
      r.shamt = 4'(n);
      r.out   = v << n;
      r.zero  = 1'b0;
    end
    return r;
  endfunction

  task automatic applyStimulus(input exp_t e);
    start  = 1'b1;
    opnd   = e.in;
    mode_s = e.mode;
    @(posedge clk);
    #1;
    e.c0 = cyc;
    q.push_back(e);
    start = 1'b0;
  endtask

  task automatic waitIdle();
    logic idle;
    idle = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !busy) begin
        idle = 1'b1;
        break;
      end
    end
    checkOutput("idle_wait", 16'(idle), 16'd1);
    if (!idle) q.delete();
  endtask

  task automatic waitDone();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("done_wait", 16'(seen), 16'd1);
  endtask

  // Scoreboard monitor: pops the expected result on each done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (done) begin
        checkOutput("done_twice", 16'(prev_done), 16'd0);
        checkOutput("busy_in_done", 16'(busy), 16'd0);
        if (q.size() == 0) begin
          checkOutput("unexpected_done", 16'(done), 16'd0);
        end else begin
          e = q.pop_front();
          checkOutput("out", out, e.out);
          checkOutput("shamt", 16'(shamt), 16'(e.shamt));
          checkOutput("zero", 16'(zero), 16'(e.zero));
          checkOutput("latency", 16'(cyc - e.c0), 16'(e.shamt) + 16'd1);
          checkOutput("out_is_shifted", out, e.in << shamt);
          if (!zero && !e.mode) checkOutput("uns_msb", 16'(out[15]), 16'd1);
          if (!zero && e.mode) begin
            checkOutput("sgn_norm", 16'(out[15] ^ out[14]), 16'd1);
            checkOutput("sgn_keep", 16'(out[15]), 16'(e.in[15]));
          end
        end
        last_out   = out;
        last_shamt = shamt;
        last_zero  = zero;
      end else if (busy) begin
        checkOutput("hold_out", out, last_out);
        checkOutput("hold_shamt", 16'(shamt), 16'(last_shamt));
        checkOutput("hold_zero", 16'(zero), 16'(last_zero));
      end
      prev_done = done;
    end
  end

  initial begin
    logic [15:0] v;
    logic        m;
    vec[0]  = mk(16'h0001, 1'b0, 16'h8000, 4'd15, 1'b0);
    vec[1]  = mk(16'h00F0, 1'b0, 16'hF000, 4'd8,  1'b0);
    vec[2]  = mk(16'hFFFE, 1'b1, 16'h8000, 4'd14, 1'b0);
    vec[3]  = mk(16'h0003, 1'b1, 16'h6000, 4'd13, 1'b0);
    vec[4]  = mk(16'h4000, 1'b1, 16'h4000, 4'd0,  1'b0);
    vec[5]  = mk(16'h0000, 1'b0, 16'h0000, 4'd0,  1'b1);
    vec[6]  = mk(16'hFFFF, 1'b1, 16'hFFFF, 4'd0,  1'b1);
    vec[7]  = mk(16'hFFFF, 1'b0, 16'hFFFF, 4'd0,  1'b0);
    vec[8]  = mk(16'h8000, 1'b0, 16'h8000, 4'd0,  1'b0);
    vec[9]  = mk(16'h0000, 1'b1, 16'h0000, 4'd0,  1'b1);
    vec[10] = mk(16'h1234, 1'b1, 16'h48D0, 4'd2,  1'b0);

    start = 1'b0; opnd = 16'h0000; mode_s = 1'b0; rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #2;
    checkOutput("rst_busy", 16'(busy), 16'd0);
    checkOutput("rst_done", 16'(done), 16'd0);
    checkOutput("rst_out", out, 16'h0000);
    checkOutput("rst_shamt", 16'(shamt), 16'd0);
    checkOutput("rst_zero", 16'(zero), 16'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] vector table");
    foreach (vec[i]) begin
      applyStimulus(vec[i]);
      waitIdle();
    end

    $display("[TB] reset during shift");
    applyStimulus(model(16'h0001, 1'b0));
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    q.delete();
    last_out = 16'h0000; last_shamt = 4'd0; last_zero = 1'b0; prev_done = 1'b0;
    #1;
    checkOutput("midrst_busy", 16'(busy), 16'd0);
    checkOutput("midrst_done", 16'(done), 16'd0);
    checkOutput("midrst_out", out, 16'h0000);
    checkOutput("midrst_shamt", 16'(shamt), 16'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    applyStimulus(model(16'h8000, 1'b0));
    waitIdle();

    $display("[TB] start held high");
    start = 1'b1; opnd = 16'h0010; mode_s = 1'b0;
    @(posedge clk);
    #1;
    q.push_back(mk(16'h0010, 1'b0, 16'h8000, 4'd11, 1'b0));
    q[q.size()-1].c0 = cyc;
    waitDone();
    start = 1'b0;
    waitIdle();

    $display("[TB] start pulses during shift");
    applyStimulus(model(16'h0001, 1'b0));
    repeat (3) @(negedge clk);
    start = 1'b1; opnd = 16'hAAAA; mode_s = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; opnd = 16'h8000; mode_s = 1'b0;
    @(negedge clk);
    start = 1'b0;
    waitIdle();

    $display("[TB] back-to-back");
    applyStimulus(model(16'h0800, 1'b0));
    waitDone();
    applyStimulus(mk(16'h0100, 1'b0, 16'h8000, 4'd7, 1'b0));
    checkOutput("b2b_busy", 16'(busy), 16'd1);
    waitIdle();

    $display("[TB] random operands");
    for (int k = 0; k < 1000; k++) begin
      v = 16'($urandom) >> $urandom_range(0, 15);
      m = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) v = ~v;
      applyStimulus(model(v, m));
      waitIdle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/normalizer.md
# normalizer

Multi-cycle left-normalizer for the 16-bit ALU datapath: given a 16-bit operand, it finds the left-shift amount that brings the operand to normalized form and returns both the shifted value and that amount. It is the inverse companion of the combinational shifter, which applies a known shift amount. This block recovers the amount, one bit position per clock, behind a start/done handshake. It serves count-leading-zeros/sign instructions and the fixed-point divide pre-scale.

## Interface
- No parameters; data width fixed at 16, shift-amount width fixed at 4.
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled on rising edge when not busy.
- in  input  16  operand, sampled together with start.
- mode  input  1  0 = unsigned (normalize until out[15]=1); 1 = signed (normalize until out[15]≠out[14]); sampled with start.
- busy  output  1  high while a normalization is in progress.
- done  output  1  one-cycle pulse; out/shamt/zero valid from this cycle on.
- out  output  16  normalized operand (in << shamt, zero-filled).
- shamt  output  4  shift amount applied, 0..15.
- zero  output  1  operand cannot be normalized (unsigned 0x0000; signed 0x0000 or 0xFFFF).

## Operation
- States: IDLE, SHIFT, DONE. Working register wreg[15:0], counter cnt[3:0], latched mode.
- IDLE or DONE, start=1: wreg←in, cnt←0, latch mode, evaluate zero condition on in; go SHIFT. start while in SHIFT is ignored and not queued.
- SHIFT, each cycle:
  - Normalized test is unsigned wreg[15]=1, or signed wreg[15]≠wreg[14].
  - If the captured operand was zero-class, or the normalized test passes, or cnt=15: go DONE.
  - Otherwise: wreg←wreg<<1 with LSB 0, cnt←cnt+1.
- Entering DONE: out←wreg, shamt←cnt, zero←zero-class flag, done←1.
- DONE lasts exactly one cycle, then goes to IDLE unless start is sampled, in which case it goes to SHIFT.
- Zero-class operand: out=in, shamt=0, zero=1.
- Otherwise zero=0, and shamt is the number of leading zeros (unsigned) or redundant sign bits (signed).
- out, shamt and zero hold their last result until the next DONE; they do not change during SHIFT.
- Signed mode never changes the sign bit of a non-zero-class operand: out[15]=in[15].

## Timing
- Reset (async assert, any state including mid-SHIFT): state=IDLE, busy=0, done=0, out=0x0000, shamt=0, zero=0, wreg/cnt=0. Any in-progress operation is abandoned with no done.
- The reset release is synchronized externally; the first start is accepted on the first edge with rst_n=1.
- start sampled on edge E0 gives busy=1 after E0.
- done=1 and the result are valid after edge E0+shamt+1; busy=0 in that same cycle.
- Latency is shamt+1 cycles: minimum 1 (already normalized or zero-class), maximum 16 (unsigned 0x0001).
- Back-to-back: start asserted during the done cycle is accepted; the next busy follows with no idle gap.
- busy is a registered state decode. done is registered, never high for two consecutive cycles.

## Test plan
- Reset mid-op: start with in=0x0001, mode=0; assert rst_n=0 on cycle 5 -> outputs immediately 0, no done pulse; the next start with in=0x8000 gives done one cycle later, shamt=0.
- Unsigned sweep: in=0x0001 -> out=0x8000, shamt=15, done 16 cycles after start. in=0x00F0 -> out=0xF000, shamt=8, done after 9 cycles.
- Signed: in=0xFFFE, mode=1 -> out=0x8000, shamt=14. in=0x0003, mode=1 -> out=0x6000, shamt=13. in=0x4000 -> shamt=0, done after 1 cycle.
- Zero-class: in=0x0000, mode=0 -> zero=1, out=0x0000, shamt=0. in=0xFFFF, mode=1 -> zero=1, out=0xFFFF. in=0xFFFF, mode=0 -> zero=0, shamt=0.
- Handshake:
  - start held high with in=0x0010 -> result shamt=11.
  - Start pulses during SHIFT are ignored: out stays at the prior result until done.
  - start during the done cycle with in=0x0100 -> second done with shamt=7, no gap.
- Random: 1000 random (in, mode) pairs -> out equals in<<shamt. Unsigned: out[15]=1 unless zero. Signed: out[15]≠out[14] unless zero. Latency is shamt+1.
